flash_sample_reader: RTL and testbench

Avalon-MM read initiator for the on-board flash memory. It fetches 32-bit words sequentially from `flash_mem_*`, splits each word into two 16-bit signed audio samples (low half first), and presents them on a valid/ready stream. The consumer is the audio playback path, which forwards samples to the codec FIFO. The block sits between the flash IP (`flash` instance) and the playback FSM in `music`.

---
 rtl/flash_sample_reader.sv | 106 ++++++++++
 tb/tb_flash_sample_reader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_sample_reader.sv
// flash_sample_reader: sequential Avalon-MM flash word reader emitting two 16-bit samples per word.
// Define FLASH_SAMPLE_SCALE_EN to arithmetic-shift each sample right by 6.
module flash_sample_reader #(
    parameter int NUM_WORDS = 2097152,
    parameter int ADDR_W    = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic              flash_mem_write,
    output logic [6:0]        flash_mem_burstcount,
    output logic [3:0]        flash_mem_byteenable,
    output logic [31:0]       flash_mem_writedata,
    input  logic              flash_mem_waitrequest,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    output logic [15:0]       sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              wrapped,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, OUT_LO, OUT_HI} state_t;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic [15:0]       sample_q, sample_d;
    logic              read_q, read_d;
    logic              valid_q, valid_d;
    logic              wrapped_q, wrapped_d;
    logic              busy_q, busy_d;

    function automatic logic [15:0] scale(input logic [15:0] h);
`ifdef FLASH_SAMPLE_SCALE_EN
        return 16'($signed(h) >>> 6);
`else
        return h;
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        word_d    = word_q;
        wrapped_d = 1'b0;
        case (state_q)
            IDLE:      state_d = en ? REQ : IDLE;
            REQ:       state_d = flash_mem_waitrequest ? REQ : WAIT_DATA;
            WAIT_DATA: begin
                word_d  = flash_mem_readdatavalid ? flash_mem_readdata : word_q;
                state_d = flash_mem_readdatavalid ? OUT_LO : WAIT_DATA;
            end
            OUT_LO:    state_d = sample_ready ? OUT_HI : OUT_LO;
            OUT_HI: begin
                if (sample_ready) begin
                    wrapped_d = addr_q == LAST_ADDR;
                    addr_d    = wrapped_d ? '0 : addr_q + ADDR_W'(1);
                    state_d   = en ? REQ : IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so they appear registered with the state.
        read_d   = state_d == REQ;
        valid_d  = (state_d == OUT_LO) || (state_d == OUT_HI);
        busy_d   = state_d != IDLE;
        sample_d = scale(state_d == OUT_HI ? word_d[31:16] : word_d[15:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            word_q    <= '0;
            sample_q  <= '0;
            read_q    <= 1'b0;
            valid_q   <= 1'b0;
            wrapped_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            word_q    <= word_d;
            sample_q  <= sample_d;
            read_q    <= read_d;
            valid_q   <= valid_d;
            wrapped_q <= wrapped_d;
            busy_q    <= busy_d;
        end
    end

    assign flash_mem_read       = read_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_write      = 1'b0;
    assign flash_mem_burstcount = 7'd1;
    assign flash_mem_byteenable = 4'hF;
    assign flash_mem_writedata  = 32'h0;
    assign sample               = sample_q;
    assign sample_valid         = valid_q;
    assign wrapped              = wrapped_q;
    assign busy                 = busy_q;
endmodule

// File: tb/tb_flash_sample_reader.sv
// tb_flash_sample_reader: directed scenarios plus randomized run against a queue-based sample model.
module tb_flash_sample_reader;
    localparam int NW = 4;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, wr = 1'b0, rdv = 1'b0, ready = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        read, write, valid, wrapped, busy;
    logic [22:0] addr;
    logic [6:0]  bc;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [15:0] sample;
    int          vectors = 0, miscompares = 0;

    flash_sample_reader #(.NUM_WORDS(NW), .ADDR_W(23)) dut (
        .clk(clk), .rst(rst), .en(en),
        .flash_mem_read(read), .flash_mem_address(addr), .flash_mem_write(write),
        .flash_mem_burstcount(bc), .flash_mem_byteenable(be), .flash_mem_writedata(wdata),
        .flash_mem_waitrequest(wr), .flash_mem_readdata(rdata), .flash_mem_readdatavalid(rdv),
        .sample(sample), .sample_valid(valid), .sample_ready(ready),
        .wrapped(wrapped), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_sample(input logic [15:0] h);
`ifdef FLASH_SAMPLE_SCALE_EN
        int v;
        v = int'($signed(h));
        v = (v >= 0) ? v / 64 : -((-v + 63) / 64);
        return 16'(v);
`else
        return h;
`endif
    endfunction

    task automatic test_reset();
        rst = 1; en = 0; wr = 0; rdv = 0; ready = 0;
        step(); step();
        vectors++; if (read !== 1'b0) begin miscompares++; $display("FAIL reset_read got %b want 0", read); end
        vectors++; if (addr !== 23'd0) begin miscompares++; $display("FAIL reset_addr got %h want 0", addr); end
        vectors++; if (sample !== 16'h0) begin miscompares++; $display("FAIL reset_sample got %h want 0", sample); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid); end
        vectors++; if (wrapped !== 1'b0) begin miscompares++; $display("FAIL reset_wrapped got %b want 0", wrapped); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if ({write, bc, be, wdata} !== {1'b0, 7'd1, 4'hF, 32'h0}) begin
            miscompares++; $display("FAIL tied_outputs got %b/%h/%h/%h want 0/01/f/0", write, bc, be, wdata);
        end
        rst = 0;
    endtask

    task automatic test_stall();
        en = 1; wr = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (read !== 1'b1 || addr !== 23'd0) begin
                miscompares++; $display("FAIL stall_hold cyc %0d got read=%b addr=%h want 1/0", i, read, addr);
            end
            step();
        end
        wr = 0;
        step();
        vectors++; if (read !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL stall_accept got read=%b busy=%b want 0/1", read, busy);
        end
    endtask

    task automatic test_basic();
        rdata = 32'h1234_ABCD; rdv = 1; ready = 1;
        step();
        rdv = 0; rdata = $urandom;
        vectors++; if (valid !== 1'b1 || sample !== ref_sample(16'hABCD)) begin
            miscompares++; $display("FAIL basic_lo got v=%b s=%h want 1/%h", valid, sample, ref_sample(16'hABCD));
        end
        step();
        vectors++; if (valid !== 1'b1 || sample !== ref_sample(16'h1234)) begin
            miscompares++; $display("FAIL basic_hi got v=%b s=%h want 1/%h", valid, sample, ref_sample(16'h1234));
        end
        step();
        vectors++; if (read !== 1'b1 || addr !== 23'd1 || valid !== 1'b0) begin
            miscompares++; $display("FAIL basic_next got read=%b addr=%h v=%b want 1/1/0", read, addr, valid);
        end
    endtask

    task automatic test_backpressure();
        wr = 0;
        step();
        ready = 0; rdata = 32'h5555_ABCD; rdv = 1;
        step();
        rdv = 0;
        for (int i = 0; i < 5; i++) begin
            vectors++; if (valid !== 1'b1 || sample !== ref_sample(16'hABCD) || read !== 1'b0) begin
                miscompares++; $display("FAIL bp_hold cyc %0d got v=%b s=%h r=%b want 1/%h/0", i, valid, sample, read, ref_sample(16'hABCD));
            end
            step();
        end
        ready = 1;
        step();
        vectors++; if (valid !== 1'b1 || sample !== ref_sample(16'h5555)) begin
            miscompares++; $display("FAIL bp_hi got v=%b s=%h want 1/%h", valid, sample, ref_sample(16'h5555));
        end
        en = 0;
        step();
        vectors++; if (busy !== 1'b0 || read !== 1'b0 || addr !== 23'd2) begin
            miscompares++; $display("FAIL bp_idle got busy=%b read=%b addr=%h want 0/0/2", busy, read, addr);
        end
        step();
        vectors++; if (read !== 1'b0) begin miscompares++; $display("FAIL bp_noread got %b want 0", read); end
    endtask

    task automatic test_reset_midread();
        en = 1; wr = 0;
        step(); step();
        rst = 1; en = 0;
        step();
        vectors++; if ({read, addr, sample, valid, wrapped, busy} !== '0) begin
            miscompares++; $display("FAIL midrst_values got r=%b a=%h s=%h v=%b w=%b b=%b want all 0", read, addr, sample, valid, wrapped, busy);
        end
        rst = 0; rdata = 32'hFFFF_FFFF; rdv = 1;
        step();
        rdv = 0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (valid !== 1'b0 || sample !== 16'h0) begin
                miscompares++; $display("FAIL midrst_drop cyc %0d got v=%b s=%h want 0/0", i, valid, sample);
            end
            step();
        end
        en = 1;
        step();
        vectors++; if (read !== 1'b1 || addr !== 23'd0) begin
            miscompares++; $display("FAIL midrst_restart got read=%b addr=%h want 1/0", read, addr);
        end
        en = 0;
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        int wraps = 0;
        rst = 1; step(); rst = 0;
        en = 1; ready = 1; wr = 0;
        for (int k = 0; k < 5; k++) begin
            for (int n = 0; n < 10 && read !== 1'b1; n++) step();
            vectors++; if (read !== 1'b1 || addr !== 23'(k % NW)) begin
                miscompares++; $display("FAIL wrap_addr word %0d got read=%b addr=%h want 1/%h", k, read, addr, k % NW);
            end
            step();
            d = $urandom; rdata = d; rdv = 1;
            step();
            rdv = 0;
            vectors++; if (sample !== ref_sample(d[15:0])) begin
                miscompares++; $display("FAIL wrap_lo word %0d got %h want %h", k, sample, ref_sample(d[15:0]));
            end
            step();
            vectors++; if (sample !== ref_sample(d[31:16])) begin
                miscompares++; $display("FAIL wrap_hi word %0d got %h want %h", k, sample, ref_sample(d[31:16]));
            end
            step();
            vectors++; if (wrapped !== (k % NW == NW - 1)) begin
                miscompares++; $display("FAIL wrap_pulse word %0d got %b want %b", k, wrapped, k % NW == NW - 1);
            end
            if (wrapped === 1'b1) begin
                wraps++;
                vectors++; if (addr !== 23'd0) begin miscompares++; $display("FAIL wrap_addr0 got %h want 0", addr); end
            end
        end
        vectors++; if (wraps != 1) begin miscompares++; $display("FAIL wrap_count got %0d want 1", wraps); end
        en = 0;
    endtask

    task automatic test_scale();
        logic [15:0] lo, hi;
`ifdef FLASH_SAMPLE_SCALE_EN
        lo = 16'hFE00; hi = 16'h01FF;
`else
        lo = 16'h8000; hi = 16'h7FC0;
`endif
        rst = 1; step(); rst = 0;
        en = 1; wr = 0; ready = 1;
        for (int n = 0; n < 10 && read !== 1'b1; n++) step();
        step();
        rdata = 32'h7FC0_8000; rdv = 1;
        step();
        rdv = 0;
        vectors++; if (sample !== lo) begin miscompares++; $display("FAIL scale_lo got %h want %h", sample, lo); end
        step();
        vectors++; if (sample !== hi) begin miscompares++; $display("FAIL scale_hi got %h want %h", sample, hi); end
        en = 0;
        step();
    endtask

    task automatic test_random();
        logic [15:0] q[$];
        logic [31:0] d;
        int exp_addr = 0, words = 0, delay = 0, pops = 0;
        bit outstanding = 0, exp_wrap = 0;
        rst = 1; en = 0; rdv = 0; wr = 0; ready = 0;
        step();
        rst = 0;
        for (int cyc = 0; cyc < 4000 && words < 40; cyc++) begin
            step();
            vectors++; if (wrapped !== exp_wrap) begin
                miscompares++; $display("FAIL rnd_wrapped cyc %0d got %b want %b", cyc, wrapped, exp_wrap);
            end
            vectors++; if (valid !== (q.size() != 0)) begin
                miscompares++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, valid, q.size() != 0);
            end
            if (valid === 1'b1 && q.size() != 0) begin
                vectors++; if (sample !== q[0]) begin
                    miscompares++; $display("FAIL rnd_sample cyc %0d got %h want %h", cyc, sample, q[0]);
                end
            end
            if (read === 1'b1) begin
                vectors++; if (addr !== 23'(exp_addr) || q.size() != 0 || outstanding) begin
                    miscompares++; $display("FAIL rnd_read cyc %0d got addr=%h want %h (single outstanding)", cyc, addr, exp_addr);
                end
            end
            exp_wrap = 0;
            ready = ($urandom % 3) != 0;
            if (valid === 1'b1 && ready && q.size() != 0) begin
                void'(q.pop_front());
                pops++;
                if (pops % 2 == 0) begin
                    words++;
                    exp_wrap = exp_addr == NW - 1;
                    exp_addr = (exp_addr + 1) % NW;
                end
            end
            if (outstanding && delay == 0) begin
                d = $urandom; rdata = d; rdv = 1;
                q.push_back(ref_sample(d[15:0]));
                q.push_back(ref_sample(d[31:16]));
                outstanding = 0;
            end else begin
                if (outstanding) delay--;
                rdv = !outstanding && ($urandom % 6 == 0);
                rdata = $urandom;
            end
            wr = ($urandom % 3) == 0;
            if (read === 1'b1 && !wr) begin
                outstanding = 1;
                delay = $urandom % 4;
            end
            en = ($urandom % 8) != 0;
        end
        vectors++; if (words < 40) begin miscompares++; $display("FAIL rnd_progress got %0d words want 40", words); end
        en = 0; rdv = 0;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_basic();
        test_backpressure();
        test_reset_midread();
        test_wrap();
        test_scale();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
